// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : IF/ID pipeline register. Captures the fetched instruction,
//                its PC and PC+4 every cycle, honours hazard stall and branch
//                flush, inserts NOP bubbles and counts them (saturating).
//                Register-index fields of the held instruction are exposed
//                for the register file and hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INSTR_W  = 32,
    parameter logic [INSTR_W-1:0] NOP_WORD = 32'hD503201F,
    parameter int                 CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active-low
    input  logic [ADDR_W-1:0]  if_pc,
    input  logic [ADDR_W-1:0]  if_pc_plus4,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic               if_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_plus4,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_valid,
    output logic [4:0]         id_rd,
    output logic [4:0]         id_rn,
    output logic [4:0]         id_rm,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam logic [CNT_W-1:0]  C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] C_PC_ZERO = {ADDR_W{1'b0}};

    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;
    logic [INSTR_W-1:0] instr_q,    instr_d;
    logic               valid_q,    valid_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    // A bubble is inserted on flush (which overrides stall) or on an
    // unstalled cycle with no valid fetch data.
    logic w_bubble;
    logic w_load;

    assign w_bubble = flush | (~stall & ~if_valid);
    assign w_load   = ~flush & ~stall & if_valid;

    // Next-state selection: flush > stall > load; stall simply holds.
    always_comb begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;

        if (w_bubble) begin
            pc_d       = C_PC_ZERO;
            pc_plus4_d = C_PC_ZERO;
            instr_d    = NOP_WORD;
            valid_d    = 1'b0;
            // Saturate rather than wrap so a long-running count stays meaningful.
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + C_CNT_ONE;
            end
        end else if (w_load) begin
            pc_d       = if_pc;
            pc_plus4_d = if_pc_plus4;
            instr_d    = if_instr;
            valid_d    = 1'b1;
        end
    end

    // Pipeline state register; reset forces a NOP bubble immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= C_PC_ZERO;
            pc_plus4_q <= C_PC_ZERO;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign id_pc        = pc_q;
    assign id_pc_plus4  = pc_plus4_q;
    assign id_instr     = instr_q;
    assign id_valid     = valid_q;
    assign bubble_count = cnt_q;

    // Register-index fields are plain slices of the held instruction.
    assign id_rd = instr_q[4:0];
    assign id_rn = instr_q[9:5];
    assign id_rm = instr_q[20:16];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Directed self-checking bench for if_id_stage. A default
//                build and a CNT_W=4 build share the same stimulus; the
//                narrow build exercises counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    localparam logic [31:0] C_NOP = 32'hD503201F;

    logic        clk;
    logic        rst;
    logic [63:0] if_pc;
    logic [63:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        stall;
    logic        flush;

    logic [63:0] id_pc,       s_id_pc;
    logic [63:0] id_pc_plus4, s_id_pc_plus4;
    logic [31:0] id_instr,    s_id_instr;
    logic        id_valid,    s_id_valid;
    logic [4:0]  id_rd,  id_rn,  id_rm;
    logic [4:0]  s_id_rd, s_id_rn, s_id_rm;
    logic [31:0] bubble_count;
    logic [3:0]  s_bubble_count;

    int checks   = 0;
    int failures = 0;

    if_id_stage u_dut (
        .clk          (clk),
        .rst          (rst),
        .if_pc        (if_pc),
        .if_pc_plus4  (if_pc_plus4),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .stall        (stall),
        .flush        (flush),
        .id_pc        (id_pc),
        .id_pc_plus4  (id_pc_plus4),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .id_rd        (id_rd),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .bubble_count (bubble_count)
    );

    if_id_stage #(.CNT_W(4)) u_dut_small (
        .clk          (clk),
        .rst          (rst),
        .if_pc        (if_pc),
        .if_pc_plus4  (if_pc_plus4),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .stall        (stall),
        .flush        (flush),
        .id_pc        (s_id_pc),
        .id_pc_plus4  (s_id_pc_plus4),
        .id_instr     (s_id_instr),
        .id_valid     (s_id_valid),
        .id_rd        (s_id_rd),
        .id_rn        (s_id_rn),
        .id_rm        (s_id_rm),
        .bubble_count (s_bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] instr,
                         input logic v, input logic st, input logic fl);
        if_pc       = pc;
        if_pc_plus4 = pc + 64'd4;
        if_instr    = instr;
        if_valid    = v;
        stall       = st;
        flush       = fl;
    endtask

    // Checks the full bubble state (PCs zero, NOP, invalid) on the main DUT.
    task automatic chk_bubble(input string tag, input logic [31:0] exp_cnt);
        chk({tag, "_pc"},    id_pc,        64'h0);
        chk({tag, "_pc4"},   id_pc_plus4,  64'h0);
        chk({tag, "_instr"}, {32'h0, id_instr}, {32'h0, C_NOP});
        chk({tag, "_valid"}, {63'h0, id_valid}, 64'h0);
        chk({tag, "_cnt"},   {32'h0, bubble_count}, {32'h0, exp_cnt});
    endtask

    initial begin
        rst = 1'b0;
        drive(64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        rst = 1'b1;

        // ---- Load ----
        drive(64'h40, 32'h8B020020, 1'b1, 1'b0, 1'b0);
        tick();
        chk("load_pc",    id_pc,       64'h40);
        chk("load_pc4",   id_pc_plus4, 64'h44);
        chk("load_instr", {32'h0, id_instr}, 64'h8B020020);
        chk("load_valid", {63'h0, id_valid}, 64'h1);
        chk("load_rd",    {59'h0, id_rd}, 64'd0);
        chk("load_rn",    {59'h0, id_rn}, 64'd1);
        chk("load_rm",    {59'h0, id_rm}, 64'd2);
        chk("load_cnt",   {32'h0, bubble_count}, 64'd0);

        // ---- Asynchronous reset mid-cycle while stall and flush are high ----
        stall = 1'b1;
        flush = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_bubble("rst", 32'd0);
        // NOP 0xD503201F: [4:0]=11111, [9:5]=00000, [20:16]=00011
        chk("rst_rd", {59'h0, id_rd}, 64'd31);
        chk("rst_rn", {59'h0, id_rn}, 64'd0);
        chk("rst_rm", {59'h0, id_rm}, 64'd3);
        chk("rst_small_cnt", {60'h0, s_bubble_count}, 64'd0);
        // Reset still holds across an edge with flush asserted.
        tick();
        chk("rst_hold_cnt", {32'h0, bubble_count}, 64'd0);
        #3;
        rst = 1'b1;

        // ---- Reload, then stall for 3 edges ----
        drive(64'h40, 32'h8B020020, 1'b1, 1'b0, 1'b0);
        tick();
        chk("reload_pc", id_pc, 64'h40);
        drive(64'h44, 32'h11111111, 1'b1, 1'b1, 1'b0);
        tick();
        chk("stall1_pc", id_pc, 64'h40);
        drive(64'h48, 32'h22222222, 1'b1, 1'b1, 1'b0);
        tick();
        chk("stall2_pc", id_pc, 64'h40);
        drive(64'h4C, 32'h33333333, 1'b0, 1'b1, 1'b0);
        tick();
        chk("stall3_pc",    id_pc, 64'h40);
        chk("stall3_instr", {32'h0, id_instr}, 64'h8B020020);
        chk("stall3_valid", {63'h0, id_valid}, 64'h1);
        chk("stall3_cnt",   {32'h0, bubble_count}, 64'd0);
        drive(64'h50, 32'h44444444, 1'b1, 1'b0, 1'b0);
        tick();
        chk("release_pc",    id_pc,       64'h50);
        chk("release_pc4",   id_pc_plus4, 64'h54);
        chk("release_instr", {32'h0, id_instr}, 64'h44444444);
        chk("release_cnt",   {32'h0, bubble_count}, 64'd0);

        // ---- Flush, then flush together with stall ----
        drive(64'h54, 32'h55555555, 1'b1, 1'b0, 1'b1);
        tick();
        chk_bubble("flush", 32'd1);
        drive(64'h58, 32'h66666666, 1'b1, 1'b1, 1'b1);
        tick();
        chk_bubble("flush_stall", 32'd2);
        drive(64'h60, 32'h77777777, 1'b1, 1'b0, 1'b0);
        tick();
        chk("after_flush_pc",    id_pc, 64'h60);
        chk("after_flush_valid", {63'h0, id_valid}, 64'h1);
        chk("after_flush_cnt",   {32'h0, bubble_count}, 64'd2);

        // ---- Invalid fetch for 2 edges ----
        drive(64'h64, 32'h88888888, 1'b0, 1'b0, 1'b0);
        tick();
        chk_bubble("inval1", 32'd3);
        tick();
        chk_bubble("inval2", 32'd4);
        // Stall with invalid fetch holds the count.
        stall = 1'b1;
        tick();
        chk("inval_stall_cnt", {32'h0, bubble_count}, 64'd4);
        chk("inval_stall_small_cnt", {60'h0, s_bubble_count}, 64'd4);
        stall = 1'b0;

        // ---- Saturation on the CNT_W=4 build: 14 more bubbles ----
        for (int i = 0; i < 14; i++) tick();
        chk("sat_small_cnt", {60'h0, s_bubble_count}, 64'hF);
        chk("sat_big_cnt",   {32'h0, bubble_count}, 64'd18);
        tick();
        chk("sat_small_hold", {60'h0, s_bubble_count}, 64'hF);
        chk("sat_small_instr", {32'h0, s_id_instr}, {32'h0, C_NOP});

        // ---- Sequential run: 20 fetches, PC 0..76 ----
        for (int i = 0; i < 20; i++) begin
            drive(64'(i * 4), 32'hA000_0000 | 32'(i), 1'b1, 1'b0, 1'b0);
            tick();
            chk($sformatf("seq%0d_pc", i),    id_pc,       64'(i * 4));
            chk($sformatf("seq%0d_pc4", i),   id_pc_plus4, 64'(i * 4 + 4));
            chk($sformatf("seq%0d_instr", i), {32'h0, id_instr}, {32'h0, 32'hA000_0000 | 32'(i)});
        end
        chk("seq_rd",    {59'h0, id_rd}, 64'd19);
        chk("seq_valid", {63'h0, id_valid}, 64'h1);
        chk("seq_cnt",   {32'h0, bubble_count}, 64'd19);
        chk("seq_small_pc", s_id_pc, 64'd76);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
